// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
//
// Receive-side UART for the code-density readout link. Deserialises bytes
// from RxD using an oversampling tick, then reassembles the 4-byte record
// (address high, address low, data high, data low) into one parallel
// address/data word with a single-cycle valid strobe.
//
// Build option:
//   UART_RX_PARITY_EN  - when defined, each byte carries an even-parity bit
//                        between bit 7 and the stop bit (11-bit frame).
//                        When undefined the frame is plain 8N1 (10 bits).
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous reset, active high
//   rx_en       in   oversampling tick, one-cycle pulse at OVERSAMPLE x baud
//   RxD         in   serial input, asynchronous to clk, idle high
//   rx_addr     out  address of the last complete record
//   rx_data     out  data of the last complete record
//   rx_valid    out  one-cycle pulse when a new record is latched
//   frame_err   out  one-cycle pulse when a record is discarded
//                    (bad stop bit, bad parity bit, or inter-byte timeout)
//   byte_index  out  index of the next expected byte (0..3), debug only
// ---------------------------------------------------------------------------
module uart_rx_frame #(
    parameter int WIDTH_DATA    = 16,
    parameter int LENGTH_ADDR   = 10,
    parameter int OVERSAMPLE    = 16,
    parameter int TIMEOUT_TICKS = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_en,
    input  logic                   RxD,
    output logic [LENGTH_ADDR-1:0] rx_addr,
    output logic [WIDTH_DATA-1:0]  rx_data,
    output logic                   rx_valid,
    output logic                   frame_err,
    output logic [1:0]             byte_index
);

    localparam int TCNT_W = $clog2(OVERSAMPLE);
    localparam int TO_W   = $clog2(TIMEOUT_TICKS + 1);
    localparam int AHI_W  = LENGTH_ADDR - 8;

    localparam logic [TCNT_W-1:0] TCNT_MID  = TCNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(OVERSAMPLE - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        RECOVER
    } state_t;

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic [1:0]             sync_q,    sync_d;
    state_t                 state_q,   state_d;
    logic [TCNT_W-1:0]      tcnt_q,    tcnt_d;
    logic [2:0]             bcnt_q,    bcnt_d;
    logic [7:0]             shift_q,   shift_d;
    logic                   armed_q,   armed_d;
    logic [1:0]             idx_q,     idx_d;
    logic [TO_W-1:0]        to_cnt_q,  to_cnt_d;
    logic [AHI_W-1:0]       addr_hi_q, addr_hi_d;
    logic [7:0]             addr_lo_q, addr_lo_d;
    logic [7:0]             data_hi_q, data_hi_d;
    logic [LENGTH_ADDR-1:0] rx_addr_q, rx_addr_d;
    logic [WIDTH_DATA-1:0]  rx_data_q, rx_data_d;
    logic                   rx_valid_q,  rx_valid_d;
    logic                   frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic                   par_err_q, par_err_d;
`endif

    logic rxs;       // synchronised serial input
    logic byte_ok;   // a byte finished with a good stop bit this cycle
    logic line_err;  // stop or parity failure this cycle
    logic timeout;   // inter-byte gap expired this cycle

    assign rxs    = sync_q[1];
    assign sync_d = {sync_q[0], RxD};

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so that no
        // path leaves it unassigned; otherwise synthesis infers a latch.
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        bcnt_d    = bcnt_q;
        shift_d   = shift_q;
        armed_d   = armed_q;
        idx_d     = idx_q;
        to_cnt_d  = to_cnt_q;
        addr_hi_d = addr_hi_q;
        addr_lo_d = addr_lo_q;
        data_hi_d = data_hi_q;
        rx_addr_d = rx_addr_q;
        rx_data_d = rx_data_q;
        byte_ok   = 1'b0;
        line_err  = 1'b0;
        timeout   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif

        if (rx_en) begin
            unique case (state_q)
                IDLE: begin
                    // A start bit is only honoured once the line has been
                    // seen high, so a reset released mid-byte does not lock
                    // onto the tail of that byte.
                    if (!rxs && armed_q) begin
                        state_d  = START;
                        tcnt_d   = '0;
                        to_cnt_d = '0;
                    end else begin
                        if (rxs) begin
                            armed_d = 1'b1;
                        end
                        if (idx_q != 2'd0) begin
                            if (to_cnt_q == TO_LAST) begin
                                timeout  = 1'b1;
                                to_cnt_d = '0;
                            end else begin
                                to_cnt_d = to_cnt_q + 1'b1;
                            end
                        end
                    end
                end

                START: begin
                    if (tcnt_q == TCNT_MID) begin
                        if (!rxs) begin
                            state_d = DATA;
                            tcnt_d  = '0;
                            bcnt_d  = '0;
`ifdef UART_RX_PARITY_EN
                            par_err_d = 1'b0;
`endif
                        end else begin
                            // Line went back high before mid-start: glitch.
                            state_d = IDLE;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end

                DATA: begin
                    // Counting restarts at mid-start, so TCNT_LAST lands
                    // in the middle of each data bit.
                    if (tcnt_q == TCNT_LAST) begin
                        tcnt_d  = '0;
                        shift_d = {rxs, shift_q[7:1]};
                        if (bcnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bcnt_d = bcnt_q + 1'b1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tcnt_q == TCNT_LAST) begin
                        tcnt_d  = '0;
                        state_d = STOP;
                        if (^{shift_q, rxs}) begin
                            par_err_d = 1'b1;
                            line_err  = 1'b1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
`endif

                STOP: begin
                    // Sampling mid-stop leaves half a bit of slack before
                    // a back-to-back start edge can arrive.
                    if (tcnt_q == TCNT_LAST) begin
                        tcnt_d = '0;
                        if (rxs) begin
                            state_d = IDLE;
                            byte_ok = 1'b1;
                        end else begin
                            state_d  = RECOVER;
                            line_err = 1'b1;
                        end
`ifdef UART_RX_PARITY_EN
                        // The record was already dropped at the parity
                        // bit; do not accept the byte or pulse again.
                        if (par_err_q) begin
                            byte_ok  = 1'b0;
                            line_err = 1'b0;
                        end
`endif
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end

                RECOVER: begin
                    if (rxs) begin
                        state_d = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Record assembler
        if (byte_ok) begin
            unique case (idx_q)
                2'd0: addr_hi_d = shift_q[AHI_W-1:0];
                2'd1: addr_lo_d = shift_q;
                2'd2: data_hi_d = shift_q;
                default: begin
                    rx_addr_d = {addr_hi_q, addr_lo_q};
                    rx_data_d = WIDTH_DATA'({data_hi_q, shift_q});
                end
            endcase
            idx_d = idx_q + 2'd1;
        end

        // Errors come from STOP/PARITY and timeouts only from IDLE, so
        // they never coincide with byte_ok; the OR merges any overlap
        // into a single pulse.
        if (line_err || timeout) begin
            idx_d = 2'd0;
        end

        rx_valid_d  = byte_ok && (idx_q == 2'd3);
        frame_err_d = line_err || timeout;
    end

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Idle-high reset value keeps the synchroniser from showing a
            // false start bit as reset releases.
            sync_q      <= 2'b11;
            state_q     <= IDLE;
            tcnt_q      <= '0;
            bcnt_q      <= '0;
            shift_q     <= '0;
            armed_q     <= 1'b0;
            idx_q       <= '0;
            to_cnt_q    <= '0;
            addr_hi_q   <= '0;
            addr_lo_q   <= '0;
            data_hi_q   <= '0;
            rx_addr_q   <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments here so every flop samples
            // the pre-edge values; blocking would create order races.
            sync_q      <= sync_d;
            state_q     <= state_d;
            tcnt_q      <= tcnt_d;
            bcnt_q      <= bcnt_d;
            shift_q     <= shift_d;
            armed_q     <= armed_d;
            idx_q       <= idx_d;
            to_cnt_q    <= to_cnt_d;
            addr_hi_q   <= addr_hi_d;
            addr_lo_q   <= addr_lo_d;
            data_hi_q   <= data_hi_d;
            rx_addr_q   <= rx_addr_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign rx_addr    = rx_addr_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign frame_err  = frame_err_q;
    assign byte_index = idx_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame
//
// Directed testbench for uart_rx_frame at 16x oversampling. One rx_en tick
// every four clocks; RxD changes three clocks before a tick so the
// synchroniser has settled. A negedge monitor counts rx_valid / frame_err
// high cycles, so each expected count also pins the pulse width to one cycle.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_en;
    logic        RxD;
    logic [9:0]  rx_addr;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic [1:0]  byte_index;

    int n_checks = 0;
    int n_errors = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;

    uart_rx_frame #(
        .WIDTH_DATA    (16),
        .LENGTH_ADDR   (10),
        .OVERSAMPLE    (16),
        .TIMEOUT_TICKS (1024)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_en      (rx_en),
        .RxD        (RxD),
        .rx_addr    (rx_addr),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .byte_index (byte_index)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid)              valid_cnt++;
        if (frame_err)             err_cnt++;
        if (rx_valid && frame_err) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One oversampling tick: three quiet clocks, then one rx_en cycle.
    task automatic tick();
        repeat (3) @(negedge clk);
        rx_en = 1'b1;
        @(negedge clk);
        rx_en = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_bit(input logic b);
        RxD = b;
        ticks(16);
    endtask

    task automatic idle(input int n);
        RxD = 1'b1;
        ticks(n);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit,
                             input logic par_flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^b) ^ par_flip);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        send_bit(stop_bit);
    endtask

    task automatic send_record(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
        send_byte(b0, 1'b1, 1'b0);
        send_byte(b1, 1'b1, 1'b0);
        send_byte(b2, 1'b1, 1'b0);
        send_byte(b3, 1'b1, 1'b0);
    endtask

    // Let the monitor process the current negedge before reading counts.
    task automatic settle();
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        rx_en = 1'b0;
        RxD   = 1'b1;
        repeat (3) @(negedge clk);
        settle();
        check("reset rx_addr",    32'(rx_addr),    32'h0);
        check("reset rx_data",    32'(rx_data),    32'h0);
        check("reset rx_valid",   32'(rx_valid),   32'h0);
        check("reset frame_err",  32'(frame_err),  32'h0);
        check("reset byte_index", 32'(byte_index), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle(4);

        // Record 02 A5 BE EF -> addr 2A5, data BEEF
        send_byte(8'h02, 1'b1, 1'b0);
        settle();
        check("rec1 index after b0", 32'(byte_index), 32'd1);
        send_byte(8'hA5, 1'b1, 1'b0);
        settle();
        check("rec1 index after b1", 32'(byte_index), 32'd2);
        send_byte(8'hBE, 1'b1, 1'b0);
        settle();
        check("rec1 index after b2", 32'(byte_index), 32'd3);
        check("rec1 no early valid", 32'(valid_cnt),  32'd0);
        send_byte(8'hEF, 1'b1, 1'b0);
        idle(4);
        settle();
        check("rec1 valid pulses", 32'(valid_cnt),  32'd1);
        check("rec1 err pulses",   32'(err_cnt),    32'd0);
        check("rec1 rx_addr",      32'(rx_addr),    32'h2A5);
        check("rec1 rx_data",      32'(rx_data),    32'hBEEF);
        check("rec1 byte_index",   32'(byte_index), 32'd0);

        // 4-tick low glitch on idle line
        RxD = 1'b0;
        ticks(4);
        idle(32);
        settle();
        check("glitch valid pulses", 32'(valid_cnt),  32'd1);
        check("glitch err pulses",   32'(err_cnt),    32'd0);
        check("glitch byte_index",   32'(byte_index), 32'd0);
        check("glitch rx_addr",      32'(rx_addr),    32'h2A5);

        // Byte 1 with a bad stop bit, then a clean record 01 00 12 34
        send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'h66, 1'b0, 1'b0);
        idle(16);
        settle();
        check("stop err pulses",  32'(err_cnt),    32'd1);
        check("stop byte_index",  32'(byte_index), 32'd0);
        check("stop valid count", 32'(valid_cnt),  32'd1);
        check("stop rx_addr",     32'(rx_addr),    32'h2A5);
        check("stop rx_data",     32'(rx_data),    32'hBEEF);
        send_record(8'h01, 8'h00, 8'h12, 8'h34);
        idle(4);
        settle();
        check("rec2 valid pulses", 32'(valid_cnt), 32'd2);
        check("rec2 rx_addr",      32'(rx_addr),   32'h100);
        check("rec2 rx_data",      32'(rx_data),   32'h1234);
        check("rec2 err pulses",   32'(err_cnt),   32'd1);

        // Timeout: three bytes, then idle. 7 idle ticks follow the last
        // stop sample inside its own stop bit, so 1016 more reach 1023.
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'h11, 1'b1, 1'b0);
        send_byte(8'h22, 1'b1, 1'b0);
        settle();
        check("to index before", 32'(byte_index), 32'd3);
        idle(1016);
        settle();
        check("to no err at 1023",   32'(err_cnt),    32'd1);
        check("to index at 1023",    32'(byte_index), 32'd3);
        idle(1);
        settle();
        check("to err at 1024",      32'(err_cnt),    32'd2);
        check("to index cleared",    32'(byte_index), 32'd0);
        idle(76);
        settle();
        check("to single err pulse", 32'(err_cnt),    32'd2);
        check("to rx_addr kept",     32'(rx_addr),    32'h100);
        check("to rx_data kept",     32'(rx_data),    32'h1234);
        check("to no valid",         32'(valid_cnt),  32'd2);

        // Reset in the middle of byte 2 (a 00 byte, line low)
        send_byte(8'h03, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        ticks(8);
        rst = 1'b1;
        @(negedge clk);
        settle();
        check("mid rst rx_addr",    32'(rx_addr),    32'h0);
        check("mid rst rx_data",    32'(rx_data),    32'h0);
        check("mid rst byte_index", 32'(byte_index), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ticks(8);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        send_bit(1'b1);
        idle(16);
        settle();
        check("post rst index",    32'(byte_index), 32'd0);
        check("post rst no err",   32'(err_cnt),    32'd2);
        check("post rst no valid", 32'(valid_cnt),  32'd2);
        send_record(8'h03, 8'hFF, 8'h00, 8'h01);
        idle(4);
        settle();
        check("rec3 valid pulses", 32'(valid_cnt), 32'd3);
        check("rec3 rx_addr",      32'(rx_addr),   32'h3FF);
        check("rec3 rx_data",      32'(rx_data),   32'h0001);
        check("rec3 err pulses",   32'(err_cnt),   32'd2);

`ifdef UART_RX_PARITY_EN
        // A5 has four ones: even parity bit is 0
        send_byte(8'hA5, 1'b1, 1'b1);
        idle(4);
        settle();
        check("par bad err",   32'(err_cnt),    32'd3);
        check("par bad index", 32'(byte_index), 32'd0);
        send_byte(8'hA5, 1'b1, 1'b0);
        idle(4);
        settle();
        check("par good no err", 32'(err_cnt),    32'd3);
        check("par good index",  32'(byte_index), 32'd1);
`endif

        check("valid and err never together", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Receive-side UART for the code-density readout link. Deserialises 8N1 bytes from the `RxD` pin using a 16x oversampling tick, then reassembles the 4-byte record sent by the transmitter: address high, address low, data high, data low. Each record is presented as one parallel address/data word with a single-cycle valid strobe. It sits on the host/loopback side of the link and feeds histogram capture logic or a verification scoreboard.

## Interface
- `WIDTH_DATA`, 16: record data width; bytes 2/3 are `[15:8]`/`[7:0]`.
- `LENGTH_ADDR`, 10: record address width; taken from the low bits of byte 0 and all of byte 1.
- `OVERSAMPLE`, 16: `rx_en` ticks per bit period; must be even, at least 8.
- `TIMEOUT_TICKS`, 1024: idle `rx_en` ticks allowed between bytes of one record before the partial record is dropped.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: asynchronous reset, active high.
- `rx_en` in 1: oversampling tick, one-cycle pulse at OVERSAMPLE × baud.
- `RxD` in 1: serial input, asynchronous to `clk`, idle high.
- `rx_addr` out LENGTH_ADDR: address of the last complete record.
- `rx_data` out WIDTH_DATA: data of the last complete record.
- `rx_valid` out 1: one-cycle pulse when a new record is latched.
- `frame_err` out 1: one-cycle pulse when a record is discarded because of a bad stop bit, a bad parity bit, or a timeout.
- `byte_index` out 2: index of the next expected byte (0..3), for debug.

## Operation
- Input: 2-FF synchroniser on `RxD`, both stages reset to 1. All logic uses the synchronised value `rxs`.
- Bit FSM states: IDLE, START, DATA, PARITY (macro only), STOP, RECOVER.
- The tick counter `tcnt` and bit counter `bcnt` advance only on cycles with `rx_en`.
- IDLE: `rxs` == 0 on an `rx_en` cycle moves to START with `tcnt` = 0.
- START: at `tcnt` == OVERSAMPLE/2−1, check `rxs`.
  - `rxs` == 0: go to DATA with `tcnt` and `bcnt` cleared.
  - `rxs` == 1: glitch. Return to IDLE with no error and no byte.
- DATA: sample `rxs` at every `tcnt` == OVERSAMPLE−1, i.e. mid-bit. Shift into the byte register LSB first. After bit 7, go to STOP (or to PARITY when the macro is defined).
- STOP: sample at mid-bit.
  - `rxs` == 1: byte accepted; go to IDLE.
  - `rxs` == 0: framing error; go to RECOVER.
- RECOVER: wait for `rxs` == 1 on an `rx_en` cycle, then go to IDLE.
- Assembler, on each accepted byte:
  - byte 0: `addr_hi` ← bits `[LENGTH_ADDR−9:0]`; upper bits are ignored.
  - byte 1: `addr_lo` ← byte.
  - byte 2: `data_hi` ← byte.
  - byte 3: latch {`addr_hi`, `addr_lo`} into `rx_addr`, {`data_hi`, byte} into `rx_data`, pulse `rx_valid`.
  - `byte_index` increments and wraps 3 → 0.
- Error on a stop or parity failure: `frame_err` pulses, `byte_index` ← 0, partial bytes are discarded, `rx_addr`/`rx_data` are unchanged.
- Timeout:
  - An inter-byte counter counts `rx_en` ticks while in IDLE with `byte_index` ≠ 0.
  - Reaching TIMEOUT_TICKS pulses `frame_err` and sets `byte_index` ← 0.
  - The counter clears on entry to START.
- Simultaneous events: a stop-bit error and a timeout on the same cycle produce one `frame_err` pulse. `rx_valid` and `frame_err` are never asserted together.

## Timing
- Reset values (asynchronous): FSM = IDLE, `rx_addr` = 0, `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `byte_index` = 0, all counters 0, synchroniser = 1.
- `rx_valid` asserts on the `clk` cycle after the `rx_en` cycle that samples the stop bit of byte 3, and lasts exactly one cycle. `frame_err` uses the same timing.
- The stop-bit sample falls OVERSAMPLE/2 ticks before the nominal end of the stop bit, so back-to-back bytes with a one-bit stop are received without loss.
- Reset asserted mid-byte: everything returns to reset values immediately. Bits arriving after release are ignored until the line is seen high in IDLE and a new falling edge occurs.
- The block has no backpressure. The consumer must take `rx_addr`/`rx_data` within one record time (≥ 40 bit periods).

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state follows DATA and expects an even-parity bit (XOR of the 8 data bits plus the parity bit equals 0).
  - A mismatch leads to `frame_err`, record discard and `byte_index` ← 0, then STOP is still sampled normally.
  - The frame is 11 bits.
- Undefined: the PARITY state and its logic are absent. The frame is 8N1, 10 bits.

## Test plan
- Reset, then a record addr = 10'h2A5, data = 16'hBEEF, sent as bytes 02 A5 BE EF at 16x ticks → single `rx_valid` pulse, `rx_addr` = 10'h2A5, `rx_data` = 16'hBEEF, `byte_index` = 0.
- A 4-tick low glitch on an idle `RxD` → no state change past START, no `rx_valid`, no `frame_err`.
- Byte 1 sent with stop bit = 0 → `frame_err` pulse, `byte_index` = 0; the next full record 01 00 12 34 gives `rx_addr` = 10'h100, `rx_data` = 16'h1234.
- Send 3 bytes, then hold the line idle for 1100 ticks → `frame_err` at tick 1024, `byte_index` = 0, outputs unchanged.
- Assert `rst` in the middle of byte 2, release, then send a full record 03 FF 00 01 → `rx_addr` = 10'h3FF, `rx_data` = 16'h0001.
- With `UART_RX_PARITY_EN`: byte A5 with parity bit 1 → `frame_err`; the same byte with parity bit 0 is accepted.
